pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid_if.sv | 33 +++
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid: upstream (in_*) and downstream (out_*) sides.
// The slave modport is the stage's view and the master modport is the environment's view.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Defining PIPE_STAGE_STALL_CNT_EN adds a saturating 16-bit back-pressure stall counter (stall_cnt).
module pipe_stage_skid #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  pipe_stage_skid_if.slave        bus
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  // State bits are {skid_v, main_v}.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    ONE     = 2'b01,
    INVALID = 2'b10,
    FULL    = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       occ_q, occ_d;

  logic             xfer_in;
  logic             xfer_out;
  logic             main_v;

  assign main_v   = state_q[0];
  assign xfer_in  = bus.in_valid && in_ready_q;
  assign xfer_out = main_v && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_DATA;
      skid_data_q <= RESET_DATA;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = EMPTY;
      main_data_d = RESET_DATA;
      skid_data_d = RESET_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d     = ONE;
            main_data_d = bus.in_data;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_data_d = bus.in_data;
          end else if (xfer_in) begin
            state_d     = FULL;
            skid_data_d = bus.in_data;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Precompute the registered views so in_ready never depends combinationally on out_ready.
    in_ready_d = !state_d[1];
    occ_d      = {1'b0, state_d[1]} + {1'b0, state_d[0]};
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_data_q;
  assign bus.occupancy = occ_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (main_v && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus pushes expected words, a negedge monitor pops on delivery.
// Build with PIPE_STAGE_STALL_CNT_EN defined to also exercise the stall counter.
module tb_pipe_stage_skid;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  logic flush;

  int checkCount;
  int passCount;

  logic [WIDTH-1:0] expQ[$];

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_stage_skid_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_skid #(
    .WIDTH(WIDTH),
    .RESET_DATA(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well away from the sampling edges.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                               input logic oready, input logic fl);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.out_ready = oready;
    flush         = fl;
  endtask

  // Delivery happens at the next rising edge; inputs are stable across the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: got %h, expected no delivery at %0t", bus.out_data, $time);
      end else begin
        checkOutput("scoreboard_data", {16'h0, bus.out_data}, {16'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);

    // Reset holds off capture even with in_valid asserted.
    stepCycle();
    stepCycle();
    checkOutput("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("reset_occupancy", {30'h0, bus.occupancy}, 32'h0);
    checkOutput("reset_out_data", {16'h0, bus.out_data}, 32'h0);

    expQ.push_back(16'hBEEF);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("first_out_valid", {31'h0, bus.out_valid}, 32'h1);
    checkOutput("first_out_data", {16'h0, bus.out_data}, 32'h0000BEEF);
    checkOutput("first_occupancy", {30'h0, bus.occupancy}, 32'h1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("first_drained", {30'h0, bus.occupancy}, 32'h0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
      expQ.push_back(WIDTH'(i));
      stepCycle();
      checkOutput("stream_in_ready", {31'h0, bus.in_ready}, 32'h1);
      checkOutput("stream_occupancy", {30'h0, bus.occupancy}, 32'h1);
      checkOutput("stream_out_data", {16'h0, bus.out_data}, i);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("stream_drained", {30'h0, bus.occupancy}, 32'h0);

    // Back-pressure fills the skid entry and drops in_ready.
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    expQ.push_back(16'h1111);
    stepCycle();
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    expQ.push_back(16'h2222);
    stepCycle();
    checkOutput("bp_occupancy_full", {30'h0, bus.occupancy}, 32'h2);
    checkOutput("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    expQ.push_back(16'h3333);
    stepCycle();
    stepCycle();
    checkOutput("bp_hold_occupancy", {30'h0, bus.occupancy}, 32'h2);
    checkOutput("bp_hold_out_data", {16'h0, bus.out_data}, 32'h00001111);
    checkOutput("bp_hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_data", {16'h0, bus.out_data}, 32'h00002222);
    checkOutput("bp_release_in_ready", {31'h0, bus.in_ready}, 32'h1);
    stepCycle();
    checkOutput("bp_third_data", {16'h0, bus.out_data}, 32'h00003333);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    stepCycle();
    checkOutput("bp_drained", {30'h0, bus.occupancy}, 32'h0);

    // Flush while full: held entries and the incoming word all vanish.
    applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
    expQ.push_back(16'hAAAA);
    stepCycle();
    applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
    expQ.push_back(16'hBBBB);
    stepCycle();
    applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b1);
    stepCycle();
    expQ.delete();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("flush_occupancy", {30'h0, bus.occupancy}, 32'h0);
    checkOutput("flush_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("flush_out_data", {16'h0, bus.out_data}, 32'h0);

    // Flush in ONE with an accepted incoming word: that word is discarded.
    applyStimulus(1'b1, 16'hDDDD, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'hEEEE, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("flush_one_occupancy", {30'h0, bus.occupancy}, 32'h0);

    // A same-cycle transfer-out still counts as delivered during flush.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    expQ.push_back(16'h1234);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    stepCycle();
    flush = 1'b0;
    checkOutput("flush_deliver_occupancy", {30'h0, bus.occupancy}, 32'h0);
    checkOutput("flush_deliver_queue", expQ.size(), 32'h0);

    // Asynchronous reset while full, between clock edges.
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    expQ.push_back(16'h5555);
    stepCycle();
    applyStimulus(1'b1, 16'h6666, 1'b0, 1'b0);
    expQ.push_back(16'h6666);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("async_pre_occupancy", {30'h0, bus.occupancy}, 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("async_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("async_occupancy", {30'h0, bus.occupancy}, 32'h0);
    expQ.delete();
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("async_stays_empty", {31'h0, bus.out_valid}, 32'h0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    checkOutput("stall_after_reset", {16'h0, stall_cnt}, 32'h0);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    expQ.push_back(16'h7777);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (5) stepCycle();
    checkOutput("stall_five", {16'h0, stall_cnt}, 32'h5);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    stepCycle();
    flush = 1'b0;
    checkOutput("stall_after_flush", {16'h0, stall_cnt}, 32'h5);
    applyStimulus(1'b1, 16'h8888, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (70000) stepCycle();
    checkOutput("stall_saturated", {16'h0, stall_cnt}, 32'h0000FFFF);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    stepCycle();
    flush = 1'b0;
`endif

    stepCycle();
    checkOutput("queue_drained", expQ.size(), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
